// File: rtl/mips_mem_pkg.sv
// Shared encodings for the sized MIPS data memory: access sizes and sweep FSM states.
package mips_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } mem_state_e;

endpackage

// File: rtl/mips_data_mem_sized_if.sv
// Request/response and debug signals between the MEM stage and the sized data memory.
interface mips_data_mem_sized_if #(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 12
);

   logic               i_valid;
   logic               o_ready;
   logic               i_we;
   logic [1:0]         i_size;
   logic               i_unsigned;
   logic [NB_ADDR-1:0] i_addr;
   logic [NB_DATA-1:0] i_wdata;
   logic               o_rvalid;
   logic [NB_DATA-1:0] o_rdata;
   logic               o_err;
   logic               o_busy;
   logic [NB_ADDR-1:0] i_dbg_addr;
   logic [NB_DATA-1:0] o_dbg_data;

   modport master (
      output i_valid, i_we, i_size, i_unsigned, i_addr, i_wdata, i_dbg_addr,
      input  o_ready, o_rvalid, o_rdata, o_err, o_busy, o_dbg_data
   );

   modport slave (
      input  i_valid, i_we, i_size, i_unsigned, i_addr, i_wdata, i_dbg_addr,
      output o_ready, o_rvalid, o_rdata, o_err, o_busy, o_dbg_data
   );

endinterface

// File: rtl/mem_lane_fmt.sv
// Big-endian lane formatter: byte enables, replicated store bytes, alignment error and load extension.
// Lane k is word bits [8k+7:8k] and holds byte offset 3-k, so offset 0 is the MSB.
module mem_lane_fmt
   import mips_mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  byte_en,
   output logic [31:0] wbytes,
   output logic        err,
   output logic [31:0] rext
);

   logic [1:0]  lane_idx;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      lane_idx = 2'd3 - addr_lo;
      byte_sel = rword[8*lane_idx +: 8];
      half_sel = addr_lo[1] ? rword[15:0] : rword[31:16];
      err      = 1'b0;
      byte_en  = 4'b0000;
      wbytes   = wdata;
      rext     = '0;
      case (size)
         SZ_BYTE: begin
            byte_en = 4'b0001 << lane_idx;
            wbytes  = {4{wdata[7:0]}};
            rext    = {{24{!is_unsigned && byte_sel[7]}}, byte_sel};
         end
         SZ_HALF: begin
            wbytes = {2{wdata[15:0]}};
            if (addr_lo[0]) begin
               err = 1'b1;
            end else begin
               byte_en = addr_lo[1] ? 4'b0011 : 4'b1100;
               rext    = {{16{!is_unsigned && half_sel[15]}}, half_sel};
            end
         end
         SZ_WORD: begin
            if (addr_lo != 2'b00) begin
               err = 1'b1;
            end else begin
               byte_en = 4'b1111;
               rext    = rword;
            end
         end
         default: begin
            err = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/mips_data_mem_sized.sv
// Byte-addressable big-endian data memory with sub-word loads/stores, one-cycle response
// and a post-reset zeroing sweep; a combinational debug port exposes whole words.
module mips_data_mem_sized
   import mips_mem_pkg::*;
#(
   parameter int NB_DATA      = 32,
   parameter int NB_ADDR      = 12,
   parameter bit CLEAR_ON_RST = 1'b1
) (
   input  logic                   clk,
   input  logic                   i_rst,
   mips_data_mem_sized_if.slave   bus
);

   localparam int NB_WADDR = NB_ADDR - 2;
   localparam int DEPTH    = 2**NB_WADDR;

   mem_state_e          state_reg;
   logic [NB_WADDR-1:0] clr_ptr_reg;
   logic                rvalid_reg;
   logic [NB_DATA-1:0]  rdata_reg;
   logic                err_reg;

   logic                accept;
   logic [NB_WADDR-1:0] req_widx;
   logic [NB_WADDR-1:0] dbg_widx;
   logic [NB_WADDR-1:0] wr_widx;
   logic [3:0]          lane_we;
   logic [31:0]         wr_bytes;
   logic [3:0]          byte_en;
   logic [31:0]         wbytes;
   logic                lane_err;
   logic [31:0]         rd_word;
   logic [31:0]         rext;
   logic [31:0]         dbg_word;

   assign req_widx = bus.i_addr[NB_ADDR-1:2];
   assign dbg_widx = bus.i_dbg_addr[NB_ADDR-1:2];

   // Ready is withheld in the reset cycle too, so nothing is accepted while state is reloading.
   assign bus.o_ready  = (state_reg == ST_IDLE) && !i_rst;
   assign bus.o_busy   = (state_reg == ST_CLEAR);
   assign bus.o_rvalid = rvalid_reg;
   assign bus.o_rdata  = rdata_reg;
   assign bus.o_err    = err_reg;
   assign bus.o_dbg_data = dbg_word;

   assign accept = bus.i_valid && bus.o_ready;

   mem_lane_fmt u_lane_fmt (
      .size        (bus.i_size),
      .addr_lo     (bus.i_addr[1:0]),
      .is_unsigned (bus.i_unsigned),
      .wdata       (bus.i_wdata[31:0]),
      .rword       (rd_word),
      .byte_en     (byte_en),
      .wbytes      (wbytes),
      .err         (lane_err),
      .rext        (rext)
   );

   // The sweep and requests share one write port; they are mutually exclusive by state.
   always_comb begin
      wr_widx  = req_widx;
      wr_bytes = wbytes;
      lane_we  = 4'b0000;
      if (!i_rst) begin
         if (state_reg == ST_CLEAR) begin
            wr_widx  = clr_ptr_reg;
            wr_bytes = '0;
            lane_we  = 4'b1111;
         end else if (accept && bus.i_we) begin
            lane_we = byte_en;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];

         always_ff @(posedge clk) begin
            if (lane_we[gi]) begin
               mem[wr_widx] <= wr_bytes[8*gi +: 8];
            end
         end

         assign rd_word[8*gi +: 8]  = mem[req_widx];
         assign dbg_word[8*gi +: 8] = mem[dbg_widx];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_reg   <= CLEAR_ON_RST ? ST_CLEAR : ST_IDLE;
         clr_ptr_reg <= '0;
         rvalid_reg  <= 1'b0;
         rdata_reg   <= '0;
         err_reg     <= 1'b0;
      end else begin
         rvalid_reg <= accept;
         case (state_reg)
            ST_CLEAR: begin
               clr_ptr_reg <= clr_ptr_reg + 1'b1;
               if (clr_ptr_reg == {NB_WADDR{1'b1}}) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
         if (accept) begin
            err_reg   <= lane_err;
            rdata_reg <= (bus.i_we || lane_err) ? '0 : rext;
         end else begin
            err_reg   <= 1'b0;
            rdata_reg <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mips_data_mem_sized.sv
// Scoreboard bench for the sized data memory: expected responses queued at drive time, popped on o_rvalid.
module tb_mips_data_mem_sized;
   import mips_mem_pkg::*;

   localparam int NB_DATA = 32;
   localparam int NB_ADDR = 6;

   typedef struct {
      logic [31:0] data;
      logic        err;
      string       tag;
   } exp_t;

   logic clk = 1'b0;
   logic i_rst = 1'b1;
   always #5 clk = ~clk;

   mips_data_mem_sized_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) bus ();

   mips_data_mem_sized #(
      .NB_DATA      (NB_DATA),
      .NB_ADDR      (NB_ADDR),
      .CLEAR_ON_RST (1'b1)
   ) dut (
      .clk   (clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   logic pending = 1'b0;
   bit   mon_en = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Every cycle: o_rvalid must equal "accepted on the previous edge"; responses pop the queue.
   always @(negedge clk) begin
      if (mon_en) begin
         check("rvalid_timing", {31'd0, bus.o_rvalid}, {31'd0, pending});
         if (bus.o_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
               mon_e = exp_q.pop_front();
               check(mon_e.tag, bus.o_rdata, mon_e.data);
               check({mon_e.tag, "_err"}, {31'd0, bus.o_err}, {31'd0, mon_e.err});
               $display("TXN %-10s rdata=%08h err=%0d", mon_e.tag, bus.o_rdata, bus.o_err);
            end
         end
         pending = bus.i_valid && bus.o_ready;
      end
   end

   // Called at posedge+1 with the block ready; returns at the next posedge+1.
   task automatic req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                      input logic [5:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_data, input logic exp_err);
      exp_t e;
      bus.i_valid    = 1'b1;
      bus.i_we       = we;
      bus.i_size     = size;
      bus.i_unsigned = uns;
      bus.i_addr     = addr;
      bus.i_wdata    = wdata;
      e.data = exp_data;
      e.err  = exp_err;
      e.tag  = tag;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Counts negedges with o_busy high; stops early after stop_at cycles when stop_at > 0.
   task automatic count_busy(output int n, input int stop_at);
      n = 0;
      @(negedge clk);
      while (bus.o_busy && n < 100 && (stop_at == 0 || n < stop_at)) begin
         n++;
         if (n == 15) bus.i_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [31:0] v;

      bus.i_valid    = 1'b0;
      bus.i_we       = 1'b0;
      bus.i_size     = SZ_WORD;
      bus.i_unsigned = 1'b0;
      bus.i_addr     = '0;
      bus.i_wdata    = '0;
      bus.i_dbg_addr = '0;
      i_rst          = 1'b1;

      // Reset state and clear sweep length
      repeat (3) @(posedge clk);
      #1;
      mon_en = 1'b1;
      @(negedge clk);
      check("rst_rdata", bus.o_rdata, 32'd0);
      check("rst_err", {31'd0, bus.o_err}, 32'd0);
      check("rst_busy", {31'd0, bus.o_busy}, 32'd1);
      check("rst_ready", {31'd0, bus.o_ready}, 32'd0);
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      count_busy(n, 0);
      check("clear_cycles", 32'(n), 32'd16);
      check("ready_after_clear", {31'd0, bus.o_ready}, 32'd1);
      @(posedge clk);
      #1;
      req("lw_3c", 1'b0, SZ_WORD, 1'b0, 6'h3C, 32'h0, 32'h0, 1'b0);

      // Sub-word loads from a stored word
      req("sw_0c",  1'b1, SZ_WORD, 1'b0, 6'h0C, 32'hDEADBEEF, 32'h0, 1'b0);
      req("lb_0c",  1'b0, SZ_BYTE, 1'b0, 6'h0C, 32'h0, 32'hFFFFFFDE, 1'b0);
      req("lbu_0d", 1'b0, SZ_BYTE, 1'b1, 6'h0D, 32'h0, 32'h000000AD, 1'b0);
      req("lh_0e",  1'b0, SZ_HALF, 1'b0, 6'h0E, 32'h0, 32'hFFFFBEEF, 1'b0);
      req("lhu_0c", 1'b0, SZ_HALF, 1'b1, 6'h0C, 32'h0, 32'h0000DEAD, 1'b0);

      // Sub-word stores merge into the word
      req("sb_0d",  1'b1, SZ_BYTE, 1'b0, 6'h0D, 32'hFFFFFF12, 32'h0, 1'b0);
      req("lw_0c_a",1'b0, SZ_WORD, 1'b0, 6'h0C, 32'h0, 32'hDE12BEEF, 1'b0);
      req("sh_0e",  1'b1, SZ_HALF, 1'b0, 6'h0E, 32'hFFFF3344, 32'h0, 1'b0);
      req("lw_0c_b",1'b0, SZ_WORD, 1'b0, 6'h0C, 32'h0, 32'hDE123344, 1'b0);
      bus.i_dbg_addr = 6'h0F;
      #1;
      check("dbg_0c", bus.o_dbg_data, 32'hDE123344);

      // Misaligned and reserved-size requests
      req("sw_00",    1'b1, SZ_WORD, 1'b0, 6'h00, 32'h11223344, 32'h0, 1'b0);
      req("lh_01",    1'b0, SZ_HALF, 1'b0, 6'h01, 32'h0, 32'h0, 1'b1);
      req("sw_02",    1'b1, SZ_WORD, 1'b0, 6'h02, 32'hAAAAAAAA, 32'h0, 1'b1);
      req("rsvd_ld",  1'b0, SZ_RSVD, 1'b0, 6'h00, 32'h0, 32'h0, 1'b1);
      req("rsvd_st",  1'b1, SZ_RSVD, 1'b0, 6'h00, 32'h55555555, 32'h0, 1'b1);
      req("lw_00",    1'b0, SZ_WORD, 1'b0, 6'h00, 32'h0, 32'h11223344, 1'b0);

      // Reset in the middle of a sweep restarts it; requests during the sweep are dropped
      req("sw_20", 1'b1, SZ_WORD, 1'b0, 6'h20, 32'hCAFEF00D, 32'h0, 1'b0);
      req("lw_20", 1'b0, SZ_WORD, 1'b0, 6'h20, 32'h0, 32'hCAFEF00D, 1'b0);
      idle(2);
      bus.i_dbg_addr = 6'h20;
      i_rst          = 1'b1;
      bus.i_valid    = 1'b1;
      bus.i_we       = 1'b0;
      bus.i_size     = SZ_WORD;
      bus.i_addr     = 6'h20;
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      count_busy(n, 5);
      check("sweep_partial", 32'(n), 32'd5);
      check("dbg_midsweep", bus.o_dbg_data, 32'hCAFEF00D);
      i_rst = 1'b1;
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      count_busy(n, 0);
      check("restart_cycles", 32'(n), 32'd16);
      check("dbg_cleared", bus.o_dbg_data, 32'h0);
      @(posedge clk);
      #1;
      req("lw_20_clr", 1'b0, SZ_WORD, 1'b0, 6'h20, 32'h0, 32'h0, 1'b0);

      // Streaming SW/LW pairs at one address, back-to-back
      bus.i_dbg_addr = 6'h12;
      for (int i = 0; i < 4; i++) begin
         v = $urandom;
         req($sformatf("stm_sw%0d", i), 1'b1, SZ_WORD, 1'b0, 6'h10, v, 32'h0, 1'b0);
         check($sformatf("stm_dbg%0d", i), bus.o_dbg_data, v);
         req($sformatf("stm_lw%0d", i), 1'b0, SZ_WORD, 1'b0, 6'h10, 32'h0, v, 1'b0);
      end

      idle(3);
      check("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
